bus_arbiter_n: RTL

//  N-master to 1-slave Avalon-MM arbiter; parametrised successor of the two-port insn/data bus arbiter.

---
 rtl/bus_arbiter_n_pkg.sv | 12 +
 rtl/bus_arb_picker.sv | 59 +++++
 rtl/bus_arbiter_n.sv | 98 +++++++++
 3 files changed

// File: rtl/bus_arbiter_n_pkg.sv
// Shared types for the N-master Avalon-MM bus arbiter.
package bus_arbiter_n_pkg;

    typedef logic [31:0] word;
    typedef logic [3:0]  nibble;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } arb_mode_t;

endpackage

// File: rtl/bus_arb_picker.sv
// Combinational winner selection: rotate the request vector past the owner,
// priority-encode, then map the rotated position back to a master index.
module bus_arb_picker
    import bus_arbiter_n_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       base,
    input  arb_mode_t              mode,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    logic [NUM_MASTERS-1:0]   masked;
    logic [NUM_MASTERS-1:0]   rotated;
    logic [2*NUM_MASTERS-1:0] doubled;
    logic [IDX_W-1:0]         shift;
    logic [IDX_W-1:0]         pos;
    logic [IDX_W:0]           sum;

    // The owner never competes against itself; only the others are candidates.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
            assign masked[gi] = req[gi] && (base != IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        shift = '0;
        if (mode == ARB_RR) begin
            shift = (base == IDX_W'(NUM_MASTERS - 1)) ? '0 : base + 1'b1;
        end
    end

    assign doubled = {masked, masked} >> shift;
    assign rotated = doubled[NUM_MASTERS-1:0];

    always_comb begin
        valid = 1'b0;
        pos   = '0;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                valid = 1'b1;
                pos   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        sum = {1'b0, pos} + {1'b0, shift};
        if (sum >= (IDX_W+1)'(NUM_MASTERS)) begin
            sum = sum - (IDX_W+1)'(NUM_MASTERS);
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master to 1-slave Avalon-MM arbiter with registered grant, round-robin or
// fixed priority, and a per-owner run limit. Read data is broadcast.
module bus_arbiter_n
    import bus_arbiter_n_pkg::*;
#(
    parameter int        NUM_MASTERS = 2,
    parameter arb_mode_t ARB_MODE    = ARB_RR,
    parameter int        MAX_RUN     = 4,
    localparam int       IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  word                    m_address    [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0] m_read,
    input  logic [NUM_MASTERS-1:0] m_write,
    input  word                    m_writedata  [NUM_MASTERS],
    input  nibble                  m_byteenable [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] m_waitrequest,
    output word                    m_readdata,
    output word                    avl_address,
    output logic                   avl_read,
    output logic                   avl_write,
    output word                    avl_writedata,
    output nibble                  avl_byteenable,
    input  word                    avl_readdata,
    input  logic                   avl_waitrequest,
    output logic [IDX_W-1:0]       grant_idx
);

    localparam int CNT_W = (MAX_RUN > 2) ? $clog2(MAX_RUN) : 1;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'((MAX_RUN > 0) ? MAX_RUN - 1 : 0);

    logic [IDX_W-1:0]       owner_reg;
    logic [CNT_W-1:0]       run_cnt_reg;
    logic                   switch_reg;
    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]       winner;
    logic                   others;
    logic                   live;
    logic                   owner_req;
    logic                   done;
    logic                   last_run;
    logic                   handover;

    assign req = m_read | m_write;

    bus_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req    (req),
        .base   (owner_reg),
        .mode   (ARB_MODE),
        .winner (winner),
        .valid  (others)
    );

    // During the switch bubble the new owner is registered but not yet on the bus.
    assign live      = rst_n && !switch_reg;
    assign owner_req = req[owner_reg] && !switch_reg;
    assign done      = owner_req && !avl_waitrequest;
    assign last_run  = (MAX_RUN != 0) && (run_cnt_reg == RUN_LAST);
    assign handover  = !switch_reg && others && (!req[owner_reg] || (done && last_run));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg   <= '0;
            run_cnt_reg <= '0;
            switch_reg  <= 1'b0;
        end else begin
            switch_reg <= handover;
            if (handover) begin
                owner_reg   <= winner;
                run_cnt_reg <= '0;
            end else if (done && !last_run && (MAX_RUN != 0)) begin
                run_cnt_reg <= run_cnt_reg + 1'b1;
            end
        end
    end

    assign avl_address    = m_address[owner_reg];
    assign avl_writedata  = m_writedata[owner_reg];
    assign avl_byteenable = m_byteenable[owner_reg];
    assign avl_read       = live && m_read[owner_reg];
    assign avl_write      = live && m_write[owner_reg];
    assign m_readdata     = avl_readdata;
    assign grant_idx      = owner_reg;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_port
            assign m_waitrequest[gi] = !(live && (owner_reg == IDX_W'(gi))) || avl_waitrequest;

            a_no_rw : assert property (@(posedge clk) disable iff (!rst_n)
                !(m_read[gi] && m_write[gi]));
        end
    endgenerate

endmodule
